// File: rtl/ibex_prefetch_queue.sv
// rtl/ibex_prefetch_queue.sv - word-granular instruction prefetcher with counter-based branch discard
module ibex_prefetch_queue #(
  parameter int unsigned NumReqs   = 2,
  parameter int unsigned FifoDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        instr_rvalid_i,
  output logic        busy_o
);

  localparam int unsigned OutW  = $clog2(NumReqs + 1);
  localparam int unsigned FifoW = $clog2(FifoDepth + 1);
  localparam int unsigned SumW  = $clog2(NumReqs + FifoDepth + 1);
  localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  logic [OutW-1:0]  out_cnt_q, out_cnt_d;
  logic [OutW-1:0]  disc_cnt_q, disc_cnt_d;
  logic [FifoW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic             hold_q, hold_d;
  logic             hold_disc_q, hold_disc_d;
  logic             halt_q, halt_d;
  logic [31:0]      stored_addr_q, stored_addr_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      head_addr_q, head_addr_d;
  logic [32:0]      mem_q [FifoDepth];
  logic [32:0]      mem_d [FifoDepth];

  logic [31:0]      addr_aligned;
  logic [31:0]      fetch_base;
  logic [SumW-1:0]  credit_sum;
  logic             new_req;
  logic             bus_gnt;
  logic             held_gnt;
  logic             drop;
  logic             push;
  logic             pop;

  assign addr_aligned = addr_i & 32'hFFFF_FFFC;
  assign credit_sum   = SumW'(fifo_cnt_q) + SumW'(out_cnt_q);

  // Reset gates the issue path so the bus sees no request while held in reset.
  assign new_req = ~rst_i & req_i & ~halt_q & ~hold_q &
                   (out_cnt_q < OutW'(NumReqs)) &
                   (branch_i | (credit_sum < SumW'(FifoDepth)));

  assign instr_req_o  = hold_q | new_req;
  assign instr_addr_o = hold_q ? stored_addr_q : (branch_i ? addr_aligned : fetch_addr_q);
  assign bus_gnt      = instr_req_o & instr_gnt_i;
  assign held_gnt     = hold_q & instr_gnt_i;

  assign drop    = instr_rvalid_i & (branch_i | (disc_cnt_q != '0));
  assign push    = instr_rvalid_i & ~drop;
  assign valid_o = (fifo_cnt_q != '0);
  assign pop     = valid_o & ready_i & ~branch_i;

  assign rdata_o = mem_q[rd_ptr_q][31:0];
  assign err_o   = mem_q[rd_ptr_q][32];
  assign addr_o  = head_addr_q;
  assign busy_o  = (out_cnt_q != '0) | instr_req_o;

  always_comb begin
    out_cnt_d     = out_cnt_q + OutW'(bus_gnt) - OutW'(instr_rvalid_i);
    hold_d        = instr_req_o & ~instr_gnt_i;
    stored_addr_d = new_req ? instr_addr_o : stored_addr_q;
    fetch_base    = branch_i ? addr_aligned : fetch_addr_q;
    fetch_addr_d  = new_req ? fetch_base + 32'd4 : fetch_base;
    disc_cnt_d    = disc_cnt_q;
    hold_disc_d   = hold_disc_q;
    halt_d        = halt_q;
    head_addr_d   = head_addr_q;
    fifo_cnt_d    = fifo_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mem_d         = mem_q;

    if (branch_i) begin
      // Everything already granted, including a held old-address request
      // granted right now, belongs to the abandoned stream.
      disc_cnt_d  = out_cnt_q - OutW'(instr_rvalid_i) + OutW'(held_gnt);
      hold_disc_d = hold_q & ~instr_gnt_i;
      halt_d      = 1'b0;
      head_addr_d = addr_aligned;
      fifo_cnt_d  = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
    end else begin
      disc_cnt_d  = disc_cnt_q - OutW'(drop) + OutW'(held_gnt & hold_disc_q);
      hold_disc_d = hold_disc_q & ~held_gnt;
      halt_d      = halt_q | (push & instr_err_i);
      if (push) begin
        mem_d[wr_ptr_q] = {instr_err_i, instr_rdata_i};
        wr_ptr_d = (wr_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d    = (rd_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        head_addr_d = head_addr_q + 32'd4;
      end
      fifo_cnt_d = fifo_cnt_q + FifoW'(push) - FifoW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_q     <= '0;
      disc_cnt_q    <= '0;
      fifo_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      hold_q        <= 1'b0;
      hold_disc_q   <= 1'b0;
      halt_q        <= 1'b0;
      stored_addr_q <= '0;
      fetch_addr_q  <= '0;
      head_addr_q   <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      out_cnt_q     <= out_cnt_d;
      disc_cnt_q    <= disc_cnt_d;
      fifo_cnt_q    <= fifo_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      hold_q        <= hold_d;
      hold_disc_q   <= hold_disc_d;
      halt_q        <= halt_d;
      stored_addr_q <= stored_addr_d;
      fetch_addr_q  <= fetch_addr_d;
      head_addr_q   <= head_addr_d;
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ibex_prefetch_queue.sv
// tb/tb_ibex_prefetch_queue.sv - directed bench for ibex_prefetch_queue (NumReqs=4, FifoDepth=4)
module tb_ibex_prefetch_queue;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b1;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic        busy_o;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  int          grant_cnt = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t rq[$];

  ibex_prefetch_queue #(.NumReqs(4), .FifoDepth(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .addr_i        (addr_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .rdata_o       (rdata_o),
    .addr_o        (addr_o),
    .err_o         (err_o),
    .instr_req_o   (instr_req_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_addr_o  (instr_addr_o),
    .instr_rdata_i (instr_rdata_i),
    .instr_err_i   (instr_err_i),
    .instr_rvalid_i(instr_rvalid_i),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  // In-order bus slave: data is the address xor K, fixed latency in cycles.
  always @(posedge clk) begin
    if (rst) begin
      rq.delete();
    end else begin
      if (instr_rvalid_i && rq.size() > 0) void'(rq.pop_front());
      if (instr_req_o && instr_gnt_i) begin
        rq.push_back('{addr: instr_addr_o, due: cyc + lat});
        grant_cnt++;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = rq[0].addr ^ K;
      instr_err_i    = (rq[0].addr == err_addr);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      instr_err_i    = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    req_i = 1'b0; branch_i = 1'b0; ready_i = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      #1;
      if (!valid_o && !busy_o && rq.size() == 0) done = 1'b1;
    end
    chk("drain_idle", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int g0;
    logic seen;

    // Reset state
    step(); step();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_req", {31'd0, instr_req_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_addr", addr_o, 32'h0);
    rst = 1'b0;
    step();

    // Sequential stream after branch to 0x100, 1-cycle latency, consumer always ready
    lat = 1; instr_gnt_i = 1'b1;
    branch_i = 1'b1; addr_i = 32'h102; req_i = 1'b1; ready_i = 1'b1;
    #1;
    chk("t1_req", {31'd0, instr_req_o}, 32'd1);
    chk("t1_bus0", instr_addr_o, 32'h100);
    step(); branch_i = 1'b0; #1;
    chk("t1_bus1", instr_addr_o, 32'h104);
    chk("t1_valid_t1", {31'd0, valid_o}, 32'd0);
    step(); #1;
    chk("t1_valid_t2", {31'd0, valid_o}, 32'd1);
    chk("t1_bus2", instr_addr_o, 32'h108);
    chk("t1_addr0", addr_o, 32'h100);
    chk("t1_data0", rdata_o, 32'h100 ^ K);
    for (int k = 1; k < 4; k++) begin
      step(); #1;
      chk("t1_addr_seq", addr_o, 32'h100 + 32'(4 * k));
      chk("t1_data_seq", rdata_o, (32'h100 + 32'(4 * k)) ^ K);
    end
    drain();

    // Credit limit: ready low, 3-cycle latency, exactly 4 grants
    lat = 3; ready_i = 1'b0; g0 = grant_cnt;
    branch_i = 1'b1; addr_i = 32'h1000; req_i = 1'b1;
    step(); branch_i = 1'b0;
    for (int k = 0; k < 7; k++) step();
    #1;
    chk("t2_grants", 32'(grant_cnt - g0), 32'd4);
    chk("t2_noreq", {31'd0, instr_req_o}, 32'd0);
    chk("t2_busy", {31'd0, busy_o}, 32'd0);
    chk("t2_head", addr_o, 32'h1000);
    ready_i = 1'b1; #1;
    chk("t2_pop_nocredit", {31'd0, instr_req_o}, 32'd0);
    chk("t2_data", rdata_o, 32'h1000 ^ K);
    step(); ready_i = 1'b0; #1;
    chk("t2_req_after_pop", {31'd0, instr_req_o}, 32'd1);
    chk("t2_bus_next", instr_addr_o, 32'h1010);
    chk("t2_head2", addr_o, 32'h1004);
    drain();

    // Two outstanding when branching to 0x200: both responses dropped
    lat = 3; ready_i = 1'b1;
    branch_i = 1'b1; addr_i = 32'h2000; req_i = 1'b1;
    step(); branch_i = 1'b0;
    step(); branch_i = 1'b1; addr_i = 32'h200; #1;
    chk("t3_bus", instr_addr_o, 32'h200);
    step(); branch_i = 1'b0; req_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_dropped", {31'd0, valid_o}, 32'd0);
      step();
    end
    #1;
    chk("t3_valid", {31'd0, valid_o}, 32'd1);
    chk("t3_addr", addr_o, 32'h200);
    chk("t3_data", rdata_o, 32'h200 ^ K);
    step(); #1;
    chk("t3_empty", {31'd0, valid_o}, 32'd0);
    drain();

    // Held request across a branch to 0x300
    lat = 1; ready_i = 1'b0; instr_gnt_i = 1'b0;
    branch_i = 1'b1; addr_i = 32'h3000; req_i = 1'b1; #1;
    chk("t4_bus_h0", instr_addr_o, 32'h3000);
    step(); branch_i = 1'b0; #1;
    chk("t4_req_h1", {31'd0, instr_req_o}, 32'd1);
    chk("t4_bus_h1", instr_addr_o, 32'h3000);
    step(); branch_i = 1'b1; addr_i = 32'h300; #1;
    chk("t4_bus_h2", instr_addr_o, 32'h3000);
    step(); branch_i = 1'b0; #1;
    chk("t4_bus_h3", instr_addr_o, 32'h3000);
    step(); instr_gnt_i = 1'b1; #1;
    chk("t4_bus_gnt", instr_addr_o, 32'h3000);
    step(); #1;
    chk("t4_bus_new", instr_addr_o, 32'h300);
    chk("t4_valid_h5", {31'd0, valid_o}, 32'd0);
    step(); req_i = 1'b0; #1;
    chk("t4_valid_h6", {31'd0, valid_o}, 32'd0);
    step(); #1;
    chk("t4_valid", {31'd0, valid_o}, 32'd1);
    chk("t4_addr", addr_o, 32'h300);
    chk("t4_data", rdata_o, 32'h300 ^ K);
    drain();

    // Bus error at 0x40C halts fetching until a branch
    lat = 1; ready_i = 1'b1; err_addr = 32'h40C;
    branch_i = 1'b1; addr_i = 32'h400; req_i = 1'b1;
    step(); branch_i = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #1;
    chk("t5_err_addr", addr_o, 32'h40C);
    chk("t5_err_flag", {31'd0, err_o}, 32'd1);
    chk("t5_halted", {31'd0, instr_req_o}, 32'd0);
    step(); #1;
    chk("t5_tail_addr", addr_o, 32'h410);
    chk("t5_tail_err", {31'd0, err_o}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step(); #1;
      chk("t5_still_halted", {31'd0, instr_req_o}, 32'd0);
    end
    step(); branch_i = 1'b1; addr_i = 32'h500;
    step(); branch_i = 1'b0; #1;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      if (instr_req_o && instr_gnt_i) seen = 1'b1;
      else begin step(); #1; end
    end
    chk("t5_resume_seen", {31'd0, seen}, 32'd1);
    chk("t5_resume_bus", instr_addr_o, 32'h500);
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      step(); #1;
      if (valid_o) seen = 1'b1;
    end
    chk("t5_resume_valid", {31'd0, seen}, 32'd1);
    chk("t5_resume_addr", addr_o, 32'h500);
    chk("t5_resume_err", {31'd0, err_o}, 32'd0);
    drain();

    // Reset with 2 outstanding and 2 FIFO entries
    lat = 3; ready_i = 1'b0; err_addr = 32'hFFFF_FFFF;
    branch_i = 1'b1; addr_i = 32'h600; req_i = 1'b1;
    step(); branch_i = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #1;
    chk("t6_pre_valid", {31'd0, valid_o}, 32'd1);
    chk("t6_pre_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1; #1;
    chk("t6_rst_valid", {31'd0, valid_o}, 32'd0);
    step(); #1;
    chk("t6_valid", {31'd0, valid_o}, 32'd0);
    chk("t6_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_req", {31'd0, instr_req_o}, 32'd0);
    chk("t6_addr", addr_o, 32'h0);
    rst = 1'b0; req_i = 1'b0;
    step(); step(); #1;
    chk("t6_post_valid", {31'd0, valid_o}, 32'd0);
    chk("t6_post_busy", {31'd0, busy_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
